// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the access-size encodings, the FSM states and the latency counter width.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_WORD = 2'b00,
      SZ_HALF = 2'b01,
      SZ_BYTE = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   // Wide enough for the largest legal latency of 15.
   localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the MEM stage (master) and the data memory (slave).
interface dmem_responder_if;

   logic        ReqValid;
   logic        ReqReady;
   logic        ReqWrite;
   logic [1:0]  ReqSize;
   logic [31:0] ReqAddr;
   logic [31:0] ReqWData;
   logic        RspValid;
   logic        RspReady;
   logic [31:0] RspRData;
   logic        RspErr;

   modport master (
      output ReqValid, ReqWrite, ReqSize, ReqAddr, ReqWData, RspReady,
      input  ReqReady, RspValid, RspRData, RspErr
   );

   modport slave (
      input  ReqValid, ReqWrite, ReqSize, ReqAddr, ReqWData, RspReady,
      output ReqReady, RspValid, RspRData, RspErr
   );

endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane select/merge for byte, half and word accesses.
// Misalign flag is only raised when DMEM_ALIGN_CHECK_EN is defined; otherwise low bits are forced.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  size_e       size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] old_word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] wr_word_o,
   output logic [31:0] rd_data_o,
   output logic        misalign_o
);

   logic [4:0] byte_sh;

   assign byte_sh = {addr_lo_i, 3'b000};

   always_comb begin
      wr_word_o  = wdata_i;
      rd_data_o  = old_word_i;
      misalign_o = 1'b0;
      case (size_i)
         SZ_BYTE: begin
            rd_data_o = (old_word_i >> byte_sh) & 32'h0000_00ff;
            wr_word_o = (old_word_i & ~(32'h0000_00ff << byte_sh))
                      | ({24'h0, wdata_i[7:0]} << byte_sh);
         end
         SZ_HALF: begin
`ifdef DMEM_ALIGN_CHECK_EN
            misalign_o = addr_lo_i[0];
`endif
            // addr[0] is dropped: the half lane is chosen by addr[1] only.
            if (addr_lo_i[1]) begin
               rd_data_o = {16'h0, old_word_i[31:16]};
               wr_word_o = {wdata_i[15:0], old_word_i[15:0]};
            end else begin
               rd_data_o = {16'h0, old_word_i[15:0]};
               wr_word_o = {old_word_i[31:16], wdata_i[15:0]};
            end
         end
         default: begin
`ifdef DMEM_ALIGN_CHECK_EN
            misalign_o = |addr_lo_i;
`endif
            rd_data_o = old_word_i;
            wr_word_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory with valid/ready request and response channels.
// Optional misalignment reporting is enabled by defining DMEM_ALIGN_CHECK_EN.
//
// state   | meaning
// IDLE    | ReqReady=1, waiting for a request
// BUSY    | latency countdown on the captured request
// RESP    | RspValid=1, holding data until RspReady
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 128,
   parameter int LATENCY = 2
) (
   input logic             Clk,
   input logic             Reset,
   dmem_responder_if.slave bus
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int ADDR_W = IDX_W + 2;
   localparam bit DIRECT = (LATENCY == 1);

   logic [31:0] mem [DEPTH];

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              cap_write_q;
   size_e             cap_size_q;
   logic [ADDR_W-1:0] cap_addr_q;
   logic [31:0]       cap_wdata_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic              accept;
   logic              enter_resp;
   logic              acc_write;
   size_e             acc_size;
   logic [ADDR_W-1:0] acc_addr;
   logic [31:0]       acc_wdata;
   logic [IDX_W-1:0]  acc_idx;
   logic [31:0]       old_word;
   logic [31:0]       lane_wr;
   logic [31:0]       lane_rd;
   logic              acc_err;
   logic [31:0]       acc_rdata;
   logic              mem_we;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^bus.ReqAddr[31:ADDR_W];

   assign accept     = bus.ReqValid && req_ready_q;
   assign enter_resp = (DIRECT && accept) || (state_q == ST_BUSY && cnt_q == '0);

   // With LATENCY==1 the access happens on the accept edge, before capture has landed.
   always_comb begin
      acc_write = cap_write_q;
      acc_size  = cap_size_q;
      acc_addr  = cap_addr_q;
      acc_wdata = cap_wdata_q;
      if (state_q == ST_IDLE) begin
         acc_write = bus.ReqWrite;
         acc_size  = size_e'(bus.ReqSize);
         acc_addr  = bus.ReqAddr[ADDR_W-1:0];
         acc_wdata = bus.ReqWData;
      end
   end

   assign acc_idx  = acc_addr[ADDR_W-1:2];
   assign old_word = mem[acc_idx];

   dmem_lane_align u_lane_align (
      .size_i     (acc_size),
      .addr_lo_i  (acc_addr[1:0]),
      .old_word_i (old_word),
      .wdata_i    (acc_wdata),
      .wr_word_o  (lane_wr),
      .rd_data_o  (lane_rd),
      .misalign_o (acc_err)
   );

   assign acc_rdata = (acc_write || acc_err) ? 32'h0 : lane_rd;
   assign mem_we    = enter_resp && acc_write && !acc_err && Reset;

   always_ff @(posedge Clk) begin
      if (mem_we) begin
         mem[acc_idx] <= lane_wr;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cap_write_q <= 1'b0;
         cap_size_q  <= SZ_WORD;
         cap_addr_q  <= '0;
         cap_wdata_q <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  cap_write_q <= bus.ReqWrite;
                  cap_size_q  <= size_e'(bus.ReqSize);
                  cap_addr_q  <= bus.ReqAddr[ADDR_W-1:0];
                  cap_wdata_q <= bus.ReqWData;
                  req_ready_q <= 1'b0;
                  if (DIRECT) begin
                     state_q     <= ST_RESP;
                     rsp_valid_q <= 1'b1;
                     rdata_q     <= acc_rdata;
                     err_q       <= acc_err;
                  end else begin
                     state_q <= ST_BUSY;
                     cnt_q   <= CNT_W'(LATENCY - 1);
                  end
               end
            end
            ST_BUSY: begin
               // cnt counts the BUSY cycles still to run after the current one.
               if (cnt_q == '0) begin
                  state_q     <= ST_RESP;
                  rsp_valid_q <= 1'b1;
                  rdata_q     <= acc_rdata;
                  err_q       <= acc_err;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_RESP: begin
               if (bus.RspReady) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  rdata_q     <= '0;
                  err_q       <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ReqReady = req_ready_q;
   assign bus.RspValid = rsp_valid_q;
   assign bus.RspRData = rdata_q;
   assign bus.RspErr   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with DEPTH=128, LATENCY=2.
module tb_dmem_responder;

   logic Clk;
   logic Reset;
   int   n_cmp;
   int   n_err;

   dmem_responder_if bus ();

   dmem_responder #(.DEPTH(128), .LATENCY(2)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d);
      @(negedge Clk);
      bus.ReqValid = 1'b1;
      bus.ReqWrite = w;
      bus.ReqSize  = sz;
      bus.ReqAddr  = a;
      bus.ReqWData = d;
      @(posedge Clk);
      #1;
      bus.ReqValid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.RspValid) break;
         @(posedge Clk);
         #1;
         lat++;
      end
   endtask

   task automatic txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic er,
                      output int lat);
      start(w, sz, a, d);
      wait_rsp(lat);
      rd = bus.RspRData;
      er = bus.RspErr;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      n_cmp = 0;
      n_err = 0;
      Reset = 1'b0;
      bus.ReqValid = 1'b0;
      bus.ReqWrite = 1'b0;
      bus.ReqSize  = 2'b00;
      bus.ReqAddr  = '0;
      bus.ReqWData = '0;
      bus.RspReady = 1'b1;
      repeat (3) @(negedge Clk);
      chk("rst_req_ready", {31'h0, bus.ReqReady}, 32'h1);
      chk("rst_rsp_valid", {31'h0, bus.RspValid}, 32'h0);
      chk("rst_rdata", bus.RspRData, 32'h0);
      chk("rst_err", {31'h0, bus.RspErr}, 32'h0);
      Reset = 1'b1;

      txn(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, rd, er, lat);
      chk("sw_lat", lat, 2);
      chk("sw_rdata", rd, 32'h0);
      chk("after_rsp_ready", {31'h0, bus.ReqReady}, 32'h1);
      chk("after_rsp_valid", {31'h0, bus.RspValid}, 32'h0);
      txn(1'b0, 2'b00, 32'h10, 32'h0, rd, er, lat);
      chk("lw_lat", lat, 2);
      chk("lw_10", rd, 32'hDEADBEEF);

      txn(1'b1, 2'b10, 32'h11, 32'hFFFFFF7F, rd, er, lat);
      txn(1'b0, 2'b00, 32'h10, 32'h0, rd, er, lat);
      chk("lw_after_sb", rd, 32'hDEAD7FEF);
      txn(1'b0, 2'b10, 32'h13, 32'h0, rd, er, lat);
      chk("lb_13", rd, 32'h000000DE);
      txn(1'b0, 2'b01, 32'h12, 32'h0, rd, er, lat);
      chk("lh_12", rd, 32'h0000DEAD);

      // Back-pressure: response held, a new request must be ignored.
      bus.RspReady = 1'b0;
      start(1'b0, 2'b00, 32'h10, 32'h0);
      wait_rsp(lat);
      chk("hold_lat", lat, 2);
      bus.ReqValid = 1'b1;
      bus.ReqWrite = 1'b1;
      bus.ReqSize  = 2'b00;
      bus.ReqAddr  = 32'h10;
      bus.ReqWData = 32'h11111111;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         chk("hold_valid", {31'h0, bus.RspValid}, 32'h1);
         chk("hold_rdata", bus.RspRData, 32'hDEAD7FEF);
         chk("hold_req_ready", {31'h0, bus.ReqReady}, 32'h0);
      end
      bus.ReqValid = 1'b0;
      bus.RspReady = 1'b1;
      @(posedge Clk);
      #1;
      chk("hold_release", {31'h0, bus.RspValid}, 32'h0);
      txn(1'b0, 2'b00, 32'h10, 32'h0, rd, er, lat);
      chk("hold_no_store", rd, 32'hDEAD7FEF);

      txn(1'b1, 2'b00, 32'h20, 32'h01234567, rd, er, lat);
      txn(1'b1, 2'b00, 32'h21, 32'hCAFEF00D, rd, er, lat);
      chk("mis_sw_rdata", rd, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
      chk("mis_sw_err", {31'h0, er}, 32'h1);
      txn(1'b0, 2'b00, 32'h20, 32'h0, rd, er, lat);
      chk("mis_lw_20", rd, 32'h01234567);
      txn(1'b1, 2'b01, 32'h22, 32'h00001234, rd, er, lat);
      txn(1'b0, 2'b00, 32'h20, 32'h0, rd, er, lat);
      chk("sh_22", rd, 32'h12344567);
      txn(1'b0, 2'b01, 32'h23, 32'h0, rd, er, lat);
      chk("mis_lh_err", {31'h0, er}, 32'h1);
      chk("mis_lh_rdata", rd, 32'h0);
`else
      chk("mis_sw_err", {31'h0, er}, 32'h0);
      txn(1'b0, 2'b00, 32'h20, 32'h0, rd, er, lat);
      chk("mis_lw_20", rd, 32'hCAFEF00D);
      txn(1'b1, 2'b01, 32'h22, 32'h00001234, rd, er, lat);
      txn(1'b0, 2'b00, 32'h20, 32'h0, rd, er, lat);
      chk("sh_22", rd, 32'h1234F00D);
      txn(1'b0, 2'b01, 32'h23, 32'h0, rd, er, lat);
      chk("mis_lh_err", {31'h0, er}, 32'h0);
      chk("mis_lh_rdata", rd, 32'h00001234);
`endif

      txn(1'b1, 2'b00, 32'h200, 32'h55AA33CC, rd, er, lat);
      txn(1'b0, 2'b00, 32'h000, 32'h0, rd, er, lat);
      chk("wrap_lw_0", rd, 32'h55AA33CC);

      // Reset while a store is still counting down.
      start(1'b1, 2'b00, 32'h10, 32'h0BADF00D);
      Reset = 1'b0;
      #2;
      chk("mid_rst_req_ready", {31'h0, bus.ReqReady}, 32'h1);
      chk("mid_rst_rsp_valid", {31'h0, bus.RspValid}, 32'h0);
      chk("mid_rst_rdata", bus.RspRData, 32'h0);
      chk("mid_rst_err", {31'h0, bus.RspErr}, 32'h0);
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      txn(1'b0, 2'b00, 32'h10, 32'h0, rd, er, lat);
      chk("mid_rst_old_data", rd, 32'hDEAD7FEF);
      chk("mid_rst_lat", lat, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
